// File: rtl/eedc_pkg.sv
// eedc_pkg: shared code constants, error codes and single-error-correcting decode helpers.
package eedc_pkg;
  localparam int CW_W = 11;
  localparam int DATA_W = 7;
  localparam int SYN_W = 4;
  localparam logic [DATA_W-1:0][SYN_W-1:0] COLS = {4'b0111, 4'b1100, 4'b1010, 4'b1001, 4'b0110, 4'b0101, 4'b0011};
  typedef enum logic [1:0] {ERR_CLEAN, ERR_CHK, ERR_DATA, ERR_UNCORR} err_e;
  typedef struct packed {
    err_e err;
    logic [DATA_W-1:0] data;
  } dec_t;
  function automatic logic [SYN_W-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] s;
    s = cw[SYN_W-1:0];
    for (int j = 0; j < DATA_W; j++) s ^= cw[SYN_W+j] ? COLS[j] : '0;
    return s;
  endfunction
  function automatic dec_t correct(input logic [CW_W-1:0] cw);
    dec_t r;
    logic [SYN_W-1:0] s;
    s = syndrome(cw);
    r.data = cw[CW_W-1:SYN_W];
    r.err = s == '0 ? ERR_CLEAN : $onehot(s) ? ERR_CHK : ERR_UNCORR;
    for (int j = 0; j < DATA_W; j++)
      if (s == COLS[j]) begin
        r.data = r.data ^ (DATA_W'(1) << j);
        r.err = ERR_DATA;
      end
    return r;
  endfunction
endpackage

// File: rtl/eedc_decode_sched_rr_arbiter.sv
// eedc_rr_arbiter: round-robin arbiter; search starts at ptr and ptr moves past each accepted winner.
module eedc_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);
  logic [ID_W-1:0] ptr;
  logic [ID_W:0] pos;
  logic found;
  always_comb begin
    found = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(k);
      pos = pos >= (ID_W+1)'(NUM_REQ) ? pos - (ID_W+1)'(NUM_REQ) : pos;
      if (!found && req[pos[ID_W-1:0]]) begin
        found = 1'b1;
        idx = pos[ID_W-1:0];
      end
    end
  end
  assign grant = (en && found) ? NUM_REQ'(1) << idx : '0;
  // explicit wrap keeps non-power-of-two requester counts in range
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (en && found) ptr <= idx == ID_W'(NUM_REQ - 1) ? '0 : idx + ID_W'(1);
endmodule

// File: rtl/eedc_decode_sched.sv
// eedc_decode_sched: shared two-stage SEC decoder with round-robin intake and tagged responses.
// Error statistics counters are built only when EEDC_SCHED_STATS_EN is defined.
module eedc_decode_sched
  import eedc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*CW_W-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [1:0]              rsp_err,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        cnt_corr,
  output logic [CNT_W-1:0]        cnt_uncorr
);
  logic [CW_W-1:0] words [NUM_REQ];
  logic [CW_W-1:0] s1_cw;
  logic [ID_W-1:0] s1_id, gidx;
  logic s1_valid, adv, s1_load;
  dec_t dec;
  for (genvar i = 0; i < NUM_REQ; i++) assign words[i] = req_data[CW_W*i +: CW_W];
  assign adv = ~rsp_valid | rsp_ready;
  assign s1_load = (adv | ~s1_valid) & ~rst;
  assign dec = correct(s1_cw);
  eedc_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .en(s1_load),
    .grant(req_ready),
    .idx(gidx)
  );
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw <= '0;
      s1_id <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_err <= ERR_CLEAN;
    end else begin
      if (s1_load) begin
        s1_valid <= |req_ready;
        s1_cw <= words[gidx];
        s1_id <= gidx;
      end
      if (adv) begin
        rsp_valid <= s1_valid;
        rsp_id <= s1_id;
        rsp_data <= dec.data;
        rsp_err <= dec.err;
      end
    end
`ifdef EEDC_SCHED_STATS_EN
  logic hs;
  assign hs = rsp_valid & rsp_ready;
  // codes 01/10 count as corrected, 11 as uncorrectable
  always_ff @(posedge clk)
    if (rst || clr_cnt) begin
      cnt_corr <= '0;
      cnt_uncorr <= '0;
    end else if (hs) begin
      if ((rsp_err[0] ^ rsp_err[1]) && !(&cnt_corr)) cnt_corr <= cnt_corr + CNT_W'(1);
      if ((&rsp_err) && !(&cnt_uncorr)) cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign cnt_corr = '0;
  assign cnt_uncorr = '0;
`endif
endmodule

// File: tb/tb_eedc_decode_sched.sv
// tb_eedc_decode_sched: vector table, directed sequences and random traffic against a queue-based reference model.
module tb_eedc_decode_sched;
  localparam int NR = 4;
  localparam int IDW = 2;
  localparam int CW = 16;
  localparam int SAT = (1 << CW) - 1;
  localparam int COLS [7] = '{3, 5, 6, 9, 10, 12, 7};
  typedef struct {
    int id;
    int data;
    int err;
    int t;
  } item_t;
  typedef struct {
    logic [10:0] cw;
    logic [6:0] d;
    logic [1:0] e;
  } vec_t;
  logic clk = 0, rst = 1, rr = 1, clr = 0;
  logic [NR-1:0] rv = '0;
  logic [10:0] wd [NR];
  logic [NR*11-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [6:0] rsp_data;
  logic [1:0] rsp_err;
  logic [CW-1:0] cnt_corr, cnt_uncorr;
  int pass_n = 0, total_n = 0, ptr_m = 0, ecount = 0, m_corr = 0, m_unc = 0;
  item_t q[$];
  vec_t tbl [10];
  assign req_data = {wd[3], wd[2], wd[1], wd[0]};
  always #5 clk = ~clk;
  eedc_decode_sched #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(rv),
    .req_ready(req_ready),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rr),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .clr_cnt(clr),
    .cnt_corr(cnt_corr),
    .cnt_uncorr(cnt_uncorr)
  );
  function automatic int enc(int d);
    int c = 0;
    for (int j = 0; j < 7; j++) if (((d >> j) & 1) == 1) c ^= COLS[j];
    return c;
  endfunction
  // decode by searching for the nearest valid codeword rather than by syndrome lookup
  function automatic int mdec(int cw);
    int f;
    if (enc(cw >> 4) == (cw & 15)) return cw >> 4;
    for (int b = 0; b < 11; b++) begin
      f = cw ^ (1 << b);
      if (enc(f >> 4) == (f & 15)) return ((b < 4 ? 1 : 2) << 8) | (f >> 4);
    end
    return (3 << 8) | (cw >> 4);
  endfunction
  task automatic chk(input string n, input int a, input int e);
    total_n++;
    if (a == e) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic step();
    int w, dv, ev;
    bit pop;
    #1;
    w = -1;
    if (q.size() < 2 || rr)
      for (int k = 0; k < NR; k++)
        if (w < 0 && rv[(ptr_m + k) % NR]) w = (ptr_m + k) % NR;
    chk("req_ready", int'(req_ready), w < 0 ? 0 : (1 << w));
    ev = int'(q.size() > 0 && q[0].t <= ecount - 1);
    chk("rsp_valid", int'(rsp_valid), ev);
    if (ev == 1) begin
      chk("rsp_id", int'(rsp_id), q[0].id);
      chk("rsp_data", int'(rsp_data), q[0].data);
      chk("rsp_err", int'(rsp_err), q[0].err);
    end
    chk("cnt_corr", int'(cnt_corr), m_corr);
    chk("cnt_uncorr", int'(cnt_uncorr), m_unc);
    pop = ev == 1 && rr;
    @(posedge clk);
    ecount++;
    if (pop) begin
`ifdef EEDC_SCHED_STATS_EN
      if (q[0].err == 1 || q[0].err == 2) m_corr = m_corr == SAT ? SAT : m_corr + 1;
      if (q[0].err == 3) m_unc = m_unc == SAT ? SAT : m_unc + 1;
`endif
      void'(q.pop_front());
    end
    if (clr) begin
      m_corr = 0;
      m_unc = 0;
    end
    if (w >= 0) begin
      dv = mdec(int'(wd[w]));
      q.push_back('{id: w, data: dv & 127, err: dv >> 8, t: ecount});
      ptr_m = (w + 1) % NR;
    end
    @(negedge clk);
  endtask
  task automatic reset_dut();
    rst = 1;
    rv = '1;
    #1;
    chk("ready_in_reset", int'(req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_data", int'(rsp_data), 0);
    chk("rst_err", int'(rsp_err), 0);
    chk("rst_cnt", int'(cnt_corr) + int'(cnt_uncorr), 0);
    rst = 0;
    rv = '0;
    q.delete();
    ptr_m = 0;
    m_corr = 0;
    m_unc = 0;
  endtask
  initial begin
    logic [6:0] held_d;
    logic [1:0] held_id;
    tbl = '{'{11'h5A1, 7'h5A, 2'b00}, '{11'h5E1, 7'h5A, 2'b10}, '{11'h5A3, 7'h5A, 2'b01},
            '{11'h591, 7'h5D, 2'b10}, '{11'h1B1, 7'h1B, 2'b01}, '{11'h00F, 7'h00, 2'b11},
            '{11'h531, 7'h43, 2'b10}, '{11'h1A0, 7'h1E, 2'b10}, '{11'h000, 7'h00, 2'b00},
            '{11'h7FF, 7'h3F, 2'b10}};
    for (int i = 0; i < NR; i++) wd[i] = '0;
    reset_dut();
    // single words from requester 2: driven after edge N, visible after edge N+2
    rr = 1;
    for (int i = 0; i < 10; i++) begin
      rv = 4'b0100;
      wd[2] = tbl[i].cw;
      step();
      rv = '0;
      step();
      #1;
      chk("tbl_valid", int'(rsp_valid), 1);
      chk("tbl_id", int'(rsp_id), 2);
      chk("tbl_data", int'(rsp_data), int'(tbl[i].d));
      chk("tbl_err", int'(rsp_err), int'(tbl[i].e));
      step();
    end
    // all requesters busy: strict rotation from ptr 0
    reset_dut();
    rv = '1;
    for (int i = 0; i < NR; i++) wd[i] = 11'(i * 37 + 5);
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("rr_order", int'(req_ready), 1 << (i % NR));
      step();
    end
    // five-cycle stall with both stages full
    rr = 0;
    #1;
    held_d = rsp_data;
    held_id = rsp_id;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_ready", int'(req_ready), 0);
      chk("stall_data", int'(rsp_data), int'(held_d));
      chk("stall_id", int'(rsp_id), int'(held_id));
      step();
    end
    rr = 1;
    for (int i = 0; i < 8; i++) step();
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      rv = NR'($urandom);
      for (int j = 0; j < NR; j++) wd[j] = 11'($urandom);
      rr = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 49) == 0;
      step();
    end
    clr = 0;
    rr = 1;
    rv = '0;
    for (int i = 0; i < 3; i++) step();
    // reset with two words in flight drops them
    rv = '1;
    step();
    step();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_valid", int'(rsp_valid), 0);
      step();
    end
    // corrected stream: saturation, then clear racing a handshake
    rv = '1;
    for (int i = 0; i < NR; i++) wd[i] = 11'h5E1;
`ifdef EEDC_SCHED_STATS_EN
    for (int i = 0; i < SAT + 4; i++) step();
    #1;
    chk("cnt_sat", int'(cnt_corr), SAT);
`else
    for (int i = 0; i < 20; i++) step();
`endif
    clr = 1;
    step();
    clr = 0;
    #1;
    chk("cnt_clr", int'(cnt_corr), 0);
    step();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
